// File: rtl/driver_power_arbiter.sv
// Round-robin power budget arbiter for H-bridge channels; grant is one clock after request.
// A request refused because MAX_ACTIVE channels are already on is held off and reported on throttled.
module driver_power_arbiter #(
  parameter int NUM_OF_DRIVERS = 16,
  parameter int MAX_ACTIVE     = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      arb_enable,
  input  logic [NUM_OF_DRIVERS-1:0] request,
  input  logic [CNT_WIDTH-1:0]      min_on_cycles,
  input  logic [CNT_WIDTH-1:0]      dead_cycles,
  output logic [NUM_OF_DRIVERS-1:0] grant,
  output logic [5:0]                active_count,
  output logic                      throttled
);

  localparam int PTR_W = $clog2(NUM_OF_DRIVERS);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_DEAD = 2'd2
  } ch_state_t;

  ch_state_t                 state_q [NUM_OF_DRIVERS];
  ch_state_t                 state_d [NUM_OF_DRIVERS];
  logic [CNT_WIDTH-1:0]      cnt_q   [NUM_OF_DRIVERS];
  logic [CNT_WIDTH-1:0]      cnt_d   [NUM_OF_DRIVERS];
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [5:0]                active_q, active_d;
  logic                      throttled_q, throttled_d;
  logic [NUM_OF_DRIVERS-1:0] eligible;
  logic                      win_vld;
  logic [PTR_W-1:0]          win_idx;
  logic [CNT_WIDTH-1:0]      hold_load;

  assign hold_load = (min_on_cycles == '0) ? CNT_WIDTH'(1) : min_on_cycles;

  // Budget is judged on the registered count, so a slot freed this edge is reusable next edge.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_p;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    idx_p   = '0;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      eligible[i] = (state_q[i] == ST_OFF) && request[i] && arb_enable;
    end
    if (active_q < 6'(MAX_ACTIVE)) begin
      for (int k = 0; k < NUM_OF_DRIVERS; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_OF_DRIVERS) idx = idx - NUM_OF_DRIVERS;
        idx_p = PTR_W'(idx);
        if (!win_vld && eligible[idx_p]) begin
          win_vld = 1'b1;
          win_idx = idx_p;
        end
      end
    end
    throttled_d = (|eligible) && (active_q >= 6'(MAX_ACTIVE));
    if (!win_vld)                                rr_ptr_d = rr_ptr_q;
    else if (win_idx == PTR_W'(NUM_OF_DRIVERS-1)) rr_ptr_d = '0;
    else                                         rr_ptr_d = win_idx + PTR_W'(1);
  end

  // Per-channel next state; the hold count is checked at <=1 so grant lasts exactly the loaded value.
  always_comb begin
    active_d = '0;
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (win_vld && (win_idx == PTR_W'(i))) begin
            state_d[i] = ST_ON;
            cnt_d[i]   = hold_load;
          end
        end
        ST_ON: begin
          if (!arb_enable || ((cnt_q[i] <= CNT_WIDTH'(1)) && !request[i])) begin
            state_d[i] = ST_DEAD;
            cnt_d[i]   = dead_cycles;
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
          end
        end
        ST_DEAD: begin
          if (cnt_q[i] == '0) state_d[i] = ST_OFF;
          else                cnt_d[i]   = cnt_q[i] - CNT_WIDTH'(1);
        end
        default: begin
          state_d[i] = ST_OFF;
          cnt_d[i]   = '0;
        end
      endcase
      active_d = active_d + {5'b0, (state_d[i] == ST_ON)};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= '0;
      end
      rr_ptr_q    <= '0;
      active_q    <= '0;
      throttled_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      active_q    <= active_d;
      throttled_q <= throttled_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_DRIVERS; i++) begin
      grant[i] = (state_q[i] == ST_ON);
    end
    active_count = active_q;
    throttled    = throttled_q;
  end

endmodule

// File: tb/tb_driver_power_arbiter.sv
// Directed bench for driver_power_arbiter: budget, round-robin wrap, hold/dead timing, disable and async reset.
module tb_driver_power_arbiter;

  logic        clock;
  logic        reset_n;
  logic        arb_enable;
  logic [15:0] request;
  logic [7:0]  min_on_cycles;
  logic [7:0]  dead_cycles;
  logic [15:0] grant;
  logic [5:0]  active_count;
  logic        throttled;

  int tests_run = 0;
  int tests_failed = 0;

  driver_power_arbiter #(
    .NUM_OF_DRIVERS(16),
    .MAX_ACTIVE    (4),
    .CNT_WIDTH     (8)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .arb_enable   (arb_enable),
    .request      (request),
    .min_on_cycles(min_on_cycles),
    .dead_cycles  (dead_cycles),
    .grant        (grant),
    .active_count (active_count),
    .throttled    (throttled)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset_n       = 1'b0;
    arb_enable    = 1'b0;
    request       = 16'h0000;
    min_on_cycles = 8'd3;
    dead_cycles   = 8'd0;
    step();
    step();
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_active", 32'(active_count), 32'd0);
    chk("reset_throttled", 32'(throttled), 32'd0);

    // Inrush: one new grant per clock until the budget of 4 is reached.
    arb_enable = 1'b1;
    request    = 16'hFFFF;
    reset_n    = 1'b1;
    step(); chk("inrush_e1", 32'(grant), 32'h0001);
    step(); chk("inrush_e2", 32'(grant), 32'h0003);
    step(); chk("inrush_e3", 32'(grant), 32'h0007);
    step(); chk("inrush_e4", 32'(grant), 32'h000F);
    chk("inrush_e4_thr", 32'(throttled), 32'd0);
    step(); chk("inrush_e5", 32'(grant), 32'h000F);
    chk("inrush_e5_active", 32'(active_count), 32'd4);
    chk("inrush_e5_thr", 32'(throttled), 32'd1);

    // ch2 releases (hold done) while ch9 waits; slot reusable only one edge later.
    request = 16'h020B;
    step();
    chk("release_grant", 32'(grant), 32'h000B);
    chk("release_active", 32'(active_count), 32'd3);
    chk("release_thr", 32'(throttled), 32'd1);
    step();
    chk("reuse_grant", 32'(grant), 32'h020B);
    chk("reuse_active", 32'(active_count), 32'd4);
    chk("reuse_thr", 32'(throttled), 32'd0);

    // Asynchronous reset mid-grant, checked before any further clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_active", 32'(active_count), 32'd0);
    chk("async_thr", 32'(throttled), 32'd0);
    step();

    // One-cycle request pulse on ch5: 5 cycles on, then at least 3 cycles off.
    hold_reset();
    arb_enable    = 1'b1;
    min_on_cycles = 8'd5;
    dead_cycles   = 8'd2;
    request       = 16'h0020;
    reset_n       = 1'b1;
    step();
    request = 16'h0000;
    chk("pulse_on1", 32'(grant), 32'h0020);
    for (int k = 2; k <= 5; k++) begin
      step();
      chk($sformatf("pulse_on%0d", k), 32'(grant), 32'h0020);
    end
    step();
    request = 16'h0020;
    chk("pulse_off1", 32'(grant), 32'h0000);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk($sformatf("pulse_off%0d", k), 32'(grant), 32'h0000);
    end
    step();
    chk("pulse_regrant", 32'(grant), 32'h0020);

    // Drive rr_ptr to 14 via a ch13 grant, then ch15 must win before ch1.
    hold_reset();
    min_on_cycles = 8'd0;
    dead_cycles   = 8'd0;
    request       = 16'h2000;
    reset_n       = 1'b1;
    step();
    chk("wrap_ch13", 32'(grant), 32'h2000);
    request = 16'h8002;
    step();
    chk("wrap_ch15", 32'(grant), 32'h8000);
    step();
    chk("wrap_ch1", 32'(grant), 32'h8002);
    chk("wrap_active", 32'(active_count), 32'd2);

    // Disable with 3 grants high and dead=4, re-enable one cycle later.
    hold_reset();
    min_on_cycles = 8'd1;
    dead_cycles   = 8'd4;
    request       = 16'h0007;
    reset_n       = 1'b1;
    step(); step(); step();
    chk("dis_pre", 32'(grant), 32'h0007);
    arb_enable = 1'b0;
    step();
    chk("dis_grant", 32'(grant), 32'h0000);
    chk("dis_active", 32'(active_count), 32'd0);
    chk("dis_thr", 32'(throttled), 32'd0);
    step();
    arb_enable = 1'b1;
    chk("dis_hold0", 32'(grant), 32'h0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("dis_dead%0d", k), 32'(grant), 32'h0000);
    end
    step();
    chk("dis_regrant", 32'(grant), 32'h0001);
    chk("dis_regrant_active", 32'(active_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
